// File: rtl/cpu_mem_responder.sv
// Word-organised RAM serving the CPU instruction port (read-only) and data port (byte-enable writes).
// It self-clears after reset. Optional build macro: STORE_FORWARD_EN forwards a colliding store to the instruction port.
module cpu_mem_responder #(
    parameter int          ADDR_BITS = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        addr_err,
    output logic [15:0] wr_count
);
    localparam int          DEPTH = 2 ** ADDR_BITS;
    localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t               state_reg;
    logic [ADDR_BITS-1:0] clr_ptr_reg;
    logic                 mem_ready_reg;
    logic                 addr_err_reg;
    logic [15:0]          wr_count_reg;

    logic [31:0]          i_off, d_off;
    logic                 i_in_range, d_in_range;
    logic                 i_misaligned, d_misaligned;
    logic [ADDR_BITS-1:0] i_idx, d_idx, ram_addr;
    logic                 ready, clr_we, wr_accept, err_hit, fwd_hit;
    logic                 i_load, d_load;
    logic [31:0]          instr_word, data_word;

    // Offsets are taken relative to the window base; compare as unsigned 33-bit to avoid overflow.
    assign i_off        = instr_addr - BASE_ADDR;
    assign d_off        = data_addr - BASE_ADDR;
    assign i_in_range   = {1'b0, i_off} < SPAN;
    assign d_in_range   = {1'b0, d_off} < SPAN;
    assign i_idx        = i_off[ADDR_BITS+1:2];
    assign d_idx        = d_off[ADDR_BITS+1:2];
    assign i_misaligned = (instr_addr[1:0] != 2'b00);
    assign d_misaligned = (data_addr[1:0] != 2'b00);

    assign ready     = rst && (state_reg == ST_READY);
    assign clr_we    = rst && (state_reg == ST_CLEAR);
    assign wr_accept = ready && (data_write != 4'b0000) && d_in_range && !d_misaligned;
    assign i_load    = ready && instr_read;
    assign d_load    = ready && data_read;
    assign ram_addr  = clr_we ? clr_ptr_reg : d_idx;

    assign err_hit = (instr_read && (!i_in_range || i_misaligned)) ||
                     (data_read && (!d_in_range || d_misaligned)) ||
                     ((data_write != 4'b0000) && (!d_in_range || d_misaligned));

`ifdef STORE_FORWARD_EN
    assign fwd_hit = wr_accept && (i_idx == d_idx);
`else
    assign fwd_hit = 1'b0;
`endif

    // One byte-wide RAM per lane keeps byte-enable writes a plain per-lane write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];
            logic       lane_we;
            logic [7:0] lane_wdata;
            logic [7:0] instr_byte_reg;
            logic [7:0] data_byte_reg;

            assign lane_we    = clr_we || (wr_accept && data_write[gi]);
            assign lane_wdata = clr_we ? 8'h00 : data_in[gi*8 +: 8];

            always_ff @(posedge clk) begin
                if (lane_we) begin
                    ram[ram_addr] <= lane_wdata;
                end
            end

            // Reads see the pre-edge contents, which gives read-before-write on collisions.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    instr_byte_reg <= 8'h00;
                    data_byte_reg  <= 8'h00;
                end else begin
                    if (i_load) begin
                        if (!i_in_range) begin
                            instr_byte_reg <= 8'h00;
                        end else if (fwd_hit && data_write[gi]) begin
                            instr_byte_reg <= data_in[gi*8 +: 8];
                        end else begin
                            instr_byte_reg <= ram[i_idx];
                        end
                    end
                    if (d_load) begin
                        data_byte_reg <= d_in_range ? ram[d_idx] : 8'h00;
                    end
                end
            end

            assign instr_word[gi*8 +: 8] = instr_byte_reg;
            assign data_word[gi*8 +: 8]  = data_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_CLEAR;
            clr_ptr_reg   <= '0;
            mem_ready_reg <= 1'b0;
            addr_err_reg  <= 1'b0;
            wr_count_reg  <= 16'h0000;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + ADDR_BITS'(1);
                    if (&clr_ptr_reg) begin
                        state_reg     <= ST_READY;
                        mem_ready_reg <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (err_hit) begin
                        addr_err_reg <= 1'b1;
                    end
                    if (wr_accept && (wr_count_reg != 16'hFFFF)) begin
                        wr_count_reg <= wr_count_reg + 16'd1;
                    end
                end
                default: state_reg <= ST_CLEAR;
            endcase
        end
    end

    assign instr_out = instr_word;
    assign data_out  = data_word;
    assign mem_ready = mem_ready_reg;
    assign addr_err  = addr_err_reg;
    assign wr_count  = wr_count_reg;

endmodule
